// File: rtl/cell_config_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : cell_config_loader_if
//  Description : Control, byte-stream and status bundle between a
//                configuration source and cell_config_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cell_config_loader_if #(
    parameter int NUM_CELLS = 4,
    parameter int CONFIG_W  = 31,
    parameter int DATA_W    = 8
);
    localparam int c_IDX_W = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

    logic                          start;
    logic                          abort;
    logic [DATA_W-1:0]             din;
    logic                          din_valid;
    logic                          din_ready;
    logic [NUM_CELLS*CONFIG_W-1:0] config_out;
    logic                          cfg_hold;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic [c_IDX_W-1:0]            cell_idx;

    // Configuration source side
    modport master (
        output start, abort, din, din_valid,
        input  din_ready, config_out, cfg_hold, busy, done, error, cell_idx
    );

    // Loader side
    modport slave (
        input  start, abort, din, din_valid,
        output din_ready, config_out, cfg_hold, busy, done, error, cell_idx
    );
endinterface

`default_nettype wire

// File: rtl/cell_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cell_config_loader
//  Description : Assembles per-cell configuration words from a byte stream
//                into shadow registers, verifies an XOR checksum and commits
//                all cells atomically. The fabric is held in reset while a
//                load is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_config_loader #(
    parameter int NUM_CELLS = 4,
    parameter int CONFIG_W  = 31,
    parameter int DATA_W    = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    cell_config_loader_if.slave bus
);

    localparam int c_BPC    = (CONFIG_W + DATA_W - 1) / DATA_W;
    localparam int c_BCNT_W = (c_BPC > 1) ? $clog2(c_BPC) : 1;
    localparam int c_IDX_W  = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam int c_FLAT_W = NUM_CELLS * CONFIG_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [CONFIG_W-1:0]   r_shadow [NUM_CELLS];
    logic [c_FLAT_W-1:0]   w_shadow_flat;
    logic [c_FLAT_W-1:0]   r_config_out;
    logic [c_BCNT_W-1:0]   r_byte_cnt;
    logic [c_IDX_W-1:0]    r_cell_idx;
    logic [DATA_W-1:0]     r_chk;
    logic                  r_cfg_hold;
    logic                  r_done;
    logic                  r_error;

    logic                  w_start_load;
    logic                  w_abort_load;
    logic                  w_load_byte;
    logic                  w_check_byte;
    logic                  w_last_byte;
    logic                  w_last_cell;
    logic                  w_chk_match;

    assign w_last_byte = (r_byte_cnt == c_BCNT_W'(c_BPC - 1));
    assign w_last_cell = (r_cell_idx == c_IDX_W'(NUM_CELLS - 1));
    assign w_chk_match = (bus.din == r_chk);

    // Flatten the shadow array in the same cell ordering as config_out
    generate
        for (genvar k = 0; k < NUM_CELLS; k++) begin : g_flat
            assign w_shadow_flat[k*CONFIG_W +: CONFIG_W] = r_shadow[k];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle action strobes; abort beats byte acceptance
    always_comb begin
        w_state_next = r_state;
        w_start_load = 1'b0;
        w_abort_load = 1'b0;
        w_load_byte  = 1'b0;
        w_check_byte = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_load = 1'b1;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    w_abort_load = 1'b1;
                    w_state_next = S_IDLE;
                end else if (bus.din_valid) begin
                    w_load_byte = 1'b1;
                    if (w_last_byte && w_last_cell) begin
                        w_state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (bus.abort) begin
                    w_abort_load = 1'b1;
                    w_state_next = S_IDLE;
                end else if (bus.din_valid) begin
                    w_check_byte = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Load bookkeeping: byte/cell counters, running checksum and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_cell_idx <= '0;
            r_chk      <= '0;
            r_cfg_hold <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_start_load) begin
                r_byte_cnt <= '0;
                r_cell_idx <= '0;
                r_chk      <= '0;
                r_cfg_hold <= 1'b1;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
            end else if (w_abort_load) begin
                r_cfg_hold <= 1'b0;
                r_error    <= 1'b1;
            end else if (w_load_byte) begin
                r_chk <= r_chk ^ bus.din;
                if (w_last_byte) begin
                    r_byte_cnt <= '0;
                    r_cell_idx <= w_last_cell ? '0 : r_cell_idx + 1'b1;
                end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end else if (w_check_byte) begin
                r_cfg_hold <= 1'b0;
                r_done     <= w_chk_match;
                r_error    <= !w_chk_match;
            end
        end
    end

    // Shadow capture, LSB-first; padding bits of a cell's last byte are dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CELLS; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_load_byte) begin
            for (int b = 0; b < CONFIG_W; b++) begin
                if (r_byte_cnt == c_BCNT_W'(b / DATA_W)) begin
                    r_shadow[r_cell_idx][b] <= bus.din[b % DATA_W];
                end
            end
        end
    end

    // Active configuration: updated as a whole only on a checksum match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_config_out <= '0;
        end else if (w_check_byte && w_chk_match) begin
            r_config_out <= w_shadow_flat;
        end
    end

    assign bus.din_ready  = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.config_out = r_config_out;
    assign bus.cfg_hold   = r_cfg_hold;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.cell_idx   = r_cell_idx;

endmodule

`default_nettype wire

// File: tb/tb_cell_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_config_loader
//  Description : Directed self-checking bench for cell_config_loader with
//                two 31-bit cells fed from an 8-bit stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_config_loader;

    localparam int c_NUM_CELLS = 2;
    localparam int c_CONFIG_W  = 31;
    localparam int c_DATA_W    = 8;

    localparam logic [61:0] c_EXP_A = {31'h7FFFFFFF, 31'h44332211};
    localparam logic [61:0] c_EXP_B = {31'h3CC35AA5, 31'h04030201};

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   c0;

    logic [7:0] s1 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] s2 [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'hC3, 8'h3C};

    cell_config_loader_if #(
        .NUM_CELLS(c_NUM_CELLS),
        .CONFIG_W (c_CONFIG_W),
        .DATA_W   (c_DATA_W)
    ) bus ();

    cell_config_loader #(
        .NUM_CELLS(c_NUM_CELLS),
        .CONFIG_W (c_CONFIG_W),
        .DATA_W   (c_DATA_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.din       = b;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_busy",     64'(bus.busy),       64'd0);
        check("rst_done",     64'(bus.done),       64'd0);
        check("rst_error",    64'(bus.error),      64'd0);
        check("rst_cfg_hold", 64'(bus.cfg_hold),   64'd0);
        check("rst_ready",    64'(bus.din_ready),  64'd0);
        check("rst_config",   64'(bus.config_out), 64'd0);
        check("rst_cell_idx", 64'(bus.cell_idx),   64'd0);

        // Bytes offered while idle are ignored
        send(8'h99);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Test 1: good load with continuous valid
        c0 = cyc;
        pulse_start();
        check("t1_busy",     64'(bus.busy),      64'd1);
        check("t1_cfg_hold", 64'(bus.cfg_hold),  64'd1);
        check("t1_ready",    64'(bus.din_ready), 64'd1);
        bus.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.din = s1[i];
            step();
            if (i == 3) check("t1_cell_idx_4b", 64'(bus.cell_idx), 64'd1);
        end
        check("t1_check_ready", 64'(bus.din_ready), 64'd1);
        check("t1_hold_pre",    64'(bus.cfg_hold),  64'd1);
        check("t1_config_pre",  64'(bus.config_out), 64'd0);
        bus.din = 8'h44;
        step();
        bus.din_valid = 1'b0;
        check("t1_done",     64'(bus.done),       64'd1);
        check("t1_error",    64'(bus.error),      64'd0);
        check("t1_cfg_hold", 64'(bus.cfg_hold),   64'd0);
        check("t1_busy_end", 64'(bus.busy),       64'd0);
        check("t1_config",   64'(bus.config_out), 64'(c_EXP_A));
        check("t1_cycles",   64'(cyc - c0),       64'd10);

        // Test 2: wrong checksum keeps prior config
        pulse_start();
        check("t2_done_clr", 64'(bus.done), 64'd0);
        for (int i = 0; i < 8; i++) send(s2[i]);
        send(8'h05);
        check("t2_error",  64'(bus.error),      64'd1);
        check("t2_done",   64'(bus.done),       64'd0);
        check("t2_hold",   64'(bus.cfg_hold),   64'd0);
        check("t2_config", 64'(bus.config_out), 64'(c_EXP_A));

        // Test 3: toggled valid gives same result
        pulse_start();
        check("t3_err_clr", 64'(bus.error), 64'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            send(s1[i]);
            if (i == 2) begin
                step();
                check("t3_stall_idx", 64'(bus.cell_idx), 64'd0);
            end
            if (i == 3) check("t3_cell_idx_4b", 64'(bus.cell_idx), 64'd1);
        end
        step();
        check("t3_stall_busy", 64'(bus.busy), 64'd1);
        send(8'h44);
        check("t3_done",   64'(bus.done),       64'd1);
        check("t3_config", 64'(bus.config_out), 64'(c_EXP_A));

        // Test 4: abort after 5 bytes, then a good load of new data
        pulse_start();
        for (int i = 0; i < 5; i++) send(s2[i]);
        bus.abort     = 1'b1;
        bus.din_valid = 1'b1;
        bus.din       = 8'h04;
        step();
        bus.abort     = 1'b0;
        bus.din_valid = 1'b0;
        check("t4_busy",   64'(bus.busy),       64'd0);
        check("t4_error",  64'(bus.error),      64'd1);
        check("t4_done",   64'(bus.done),       64'd0);
        check("t4_hold",   64'(bus.cfg_hold),   64'd0);
        check("t4_ready",  64'(bus.din_ready),  64'd0);
        check("t4_config", 64'(bus.config_out), 64'(c_EXP_A));
        pulse_start();
        for (int i = 0; i < 8; i++) send(s2[i]);
        send(8'h04);
        check("t4b_done",   64'(bus.done),       64'd1);
        check("t4b_error",  64'(bus.error),      64'd0);
        check("t4b_config", 64'(bus.config_out), 64'(c_EXP_B));

        // Abort while idle has no effect
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("idle_abort_done",  64'(bus.done),  64'd1);
        check("idle_abort_error", 64'(bus.error), 64'd0);

        // Test 5: start pulse mid-load is ignored
        pulse_start();
        send(s1[0]);
        send(s1[1]);
        bus.start = 1'b1;
        send(s1[2]);
        bus.start = 1'b0;
        check("t5_busy", 64'(bus.busy), 64'd1);
        send(s1[3]);
        check("t5_cell_idx", 64'(bus.cell_idx), 64'd1);
        for (int i = 4; i < 8; i++) send(s1[i]);
        send(8'h44);
        check("t5_done",   64'(bus.done),       64'd1);
        check("t5_config", 64'(bus.config_out), 64'(c_EXP_A));

        // Test 6: asynchronous reset mid-load
        pulse_start();
        for (int i = 0; i < 6; i++) send(s2[i]);
        #2;
        reset = 1'b1;
        #1;
        check("t6_config", 64'(bus.config_out), 64'd0);
        check("t6_busy",   64'(bus.busy),       64'd0);
        check("t6_hold",   64'(bus.cfg_hold),   64'd0);
        check("t6_ready",  64'(bus.din_ready),  64'd0);
        check("t6_done",   64'(bus.done),       64'd0);
        check("t6_error",  64'(bus.error),      64'd0);
        check("t6_idx",    64'(bus.cell_idx),   64'd0);
        step();
        reset = 1'b0;
        step();

        // start and abort together while idle: start wins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        check("sa_busy",  64'(bus.busy),  64'd1);
        check("sa_error", 64'(bus.error), 64'd0);
        step();
        bus.abort = 1'b0;
        check("sa_abort_error", 64'(bus.error), 64'd1);
        check("sa_abort_busy",  64'(bus.busy),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
